// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the execute stage.
// Signed operands are reduced to magnitudes up front and the sign is restored in FIX.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W     = WIDTH;
  localparam int unsigned P     = 2 * WIDTH;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [W-1:0]     b_mag;
  logic [W-1:0]     rs_q;
  logic [CNT_W-1:0] cnt;
  logic [P-1:0]     acc;

  logic             sign_a_in;
  logic             sign_b_in;
  logic [W-1:0]     a_mag_in;
  logic [W-1:0]     b_mag_in;
  logic [W:0]       mul_sum;
  logic [P-1:0]     mul_next;
  logic [W:0]       rem_sh;
  logic             sub_ok;
  logic [W-1:0]     rem_next;
  logic [P-1:0]     div_next;
  logic [P-1:0]     mul_res;
  logic [W-1:0]     quot_res;
  logic [W-1:0]     rem_res;
  logic             dbz_c;

  // Operand capture: signed ops (op[0] == 0) take two's-complement magnitudes.
  always_comb begin
    sign_a_in = ~op[0] & rs_data[W-1];
    sign_b_in = ~op[0] & rt_data[W-1];
    a_mag_in  = sign_a_in ? W'(-rs_data) : rs_data;
    b_mag_in  = sign_b_in ? W'(-rt_data) : rt_data;
  end

  // One shift-add / restoring-subtract step; acc holds {upper, lower} halves.
  always_comb begin
    mul_sum  = {1'b0, acc[P-1:W]} + (acc[0] ? {1'b0, b_mag} : (W+1)'(0));
    mul_next = {mul_sum, acc[W-1:1]};
    rem_sh   = {acc[P-1:W], acc[W-1]};
    sub_ok   = (rem_sh >= {1'b0, b_mag});
    rem_next = sub_ok ? W'(rem_sh - {1'b0, b_mag}) : rem_sh[W-1:0];
    div_next = {rem_next, acc[W-2:0], sub_ok};
  end

  // Sign correction applied in FIX; unsigned ops carry cleared sign flags.
  always_comb begin
    mul_res  = (sign_a ^ sign_b) ? P'(-acc) : acc;
    quot_res = (sign_a ^ sign_b) ? W'(-acc[W-1:0]) : acc[W-1:0];
    rem_res  = sign_a ? W'(-acc[P-1:W]) : acc[P-1:W];
    dbz_c    = (b_mag == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_mag       <= '0;
      rs_q        <= '0;
      acc         <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            sign_a <= sign_a_in;
            sign_b <= sign_b_in;
            b_mag  <= b_mag_in;
            rs_q   <= rs_data;
            acc    <= {W'(0), a_mag_in};
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            if (dbz_c) begin
              lo          <= '1;
              hi          <= rs_q;
              div_by_zero <= 1'b1;
            end else begin
              lo <= quot_res;
              hi <= rem_res;
            end
          end else begin
            hi <= mul_res[P-1:W];
            lo <= mul_res[W-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
